// File: rtl/c17_array_bist.sv
// rtl/c17_array_bist.sv - registered c17 NAND array with LFSR/MISR built-in self-test
module c17_array_bist #(
    parameter int          NUM_CH   = 4,
    parameter int          PIPE     = 0,
    parameter int          PATTERNS = 256,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [5*NUM_CH-1:0]   data_in,
    input  logic                  bist_start,
    output logic                  out_valid,
    output logic [2*NUM_CH-1:0]   data_out,
    output logic                  bist_busy,
    output logic                  bist_done,
    output logic [15:0]           signature
);

    localparam int DW    = 5 * NUM_CH;
    localparam int OW    = 2 * NUM_CH;
    localparam int CNT_W = $clog2(PATTERNS + 1);
    localparam int DRN_W = $clog2(PIPE + 2);

    // An all-zero seed would lock the LFSR at zero and yield a constant pattern stream.
    if (SEED == 16'h0000) begin : g_bad_seed
        $error("c17_array_bist: SEED must be nonzero");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               state;
    logic [15:0]          lfsr;
    logic [15:0]          misr;
    logic [CNT_W-1:0]     pat_cnt;
    logic [DRN_W-1:0]     drn_cnt;

    logic [DW-1:0]        in_data;
    logic                 in_vld;
    logic                 in_bist;

    logic [DW-1:0]        lfsr_vec;
    logic [NUM_CH-1:0]    c10, c16, c19;
    logic [NUM_CH-1:0]    s10, s16, s19;
    logic                 s_vld, s_bist;
    logic [OW-1:0]        out_next;
    logic [31:0]          out_pad;
    logic [15:0]          fold;
    logic                 start_go;

    assign start_go  = ((state == IDLE) || (state == DONE)) && bist_start;
    assign signature = misr;

    // Spread the 16 LFSR bits cyclically across all channel inputs.
    for (genvar i = 0; i < DW; i++) begin : g_vec
        assign lfsr_vec[i] = lfsr[i % 16];
    end

    // Per-channel first half of the c17 netlist, plus the final NAND pair.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic n1, n2, n3, n6, n7, n11;
        assign {n7, n6, n3, n2, n1} = in_data[5*c +: 5];
        assign n11           = ~(n3 & n6);
        assign c10[c]        = ~(n1 & n3);
        assign c16[c]        = ~(n2 & n11);
        assign c19[c]        = ~(n11 & n7);
        assign out_next[2*c]   = ~(s10[c] & s16[c]);
        assign out_next[2*c+1] = ~(s16[c] & s19[c]);
    end

    if (PIPE != 0) begin : g_mid
        // Optional mid-logic stage holding N10/N16/N19 with their tags.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s10    <= '0;
                s16    <= '0;
                s19    <= '0;
                s_vld  <= 1'b0;
                s_bist <= 1'b0;
            end else begin
                s10    <= c10;
                s16    <= c16;
                s19    <= c19;
                s_vld  <= in_vld;
                s_bist <= in_bist;
            end
        end
    end else begin : g_nomid
        assign s10    = c10;
        assign s16    = c16;
        assign s19    = c19;
        assign s_vld  = in_vld;
        assign s_bist = in_bist;
    end

    // Fold the result word onto 16 bits (bit i lands on bit i mod 16).
    assign out_pad = 32'(out_next);
    assign fold    = out_pad[15:0] ^ out_pad[31:16];

    // Input register: functional vectors, or LFSR patterns tagged as BIST while running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_data <= '0;
            in_vld  <= 1'b0;
            in_bist <= 1'b0;
        end else if (state == RUN) begin
            in_data <= lfsr_vec;
            in_vld  <= 1'b0;
            in_bist <= 1'b1;
        end else begin
            in_data <= data_in;
            in_vld  <= in_valid;
            in_bist <= 1'b0;
        end
    end

    // Output register; functional results keep their valid tag, BIST results never assert it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            data_out  <= out_next;
            out_valid <= s_vld;
        end
    end

    // MISR compacts each BIST result as it enters the output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misr <= 16'h0000;
        end else if (start_go) begin
            misr <= 16'h0000;
        end else if (s_bist) begin
            misr <= {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000) ^ fold;
        end
    end

    // BIST sequencer: pattern generation, pipeline drain and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lfsr      <= SEED;
            pat_cnt   <= '0;
            drn_cnt   <= '0;
            bist_busy <= 1'b0;
            bist_done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bist_start) begin
                        state     <= RUN;
                        lfsr      <= SEED;
                        pat_cnt   <= '0;
                        drn_cnt   <= '0;
                        bist_busy <= 1'b1;
                        bist_done <= 1'b0;
                    end
                end
                RUN: begin
                    lfsr    <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
                    pat_cnt <= pat_cnt + 1'b1;
                    if (pat_cnt == CNT_W'(PATTERNS - 1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drn_cnt == DRN_W'(PIPE + 1)) begin
                        state     <= DONE;
                        bist_busy <= 1'b0;
                        bist_done <= 1'b1;
                    end else begin
                        drn_cnt <= drn_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_c17_array_bist.sv
// tb/tb_c17_array_bist.sv - self-checking bench for c17_array_bist (PIPE=0 and PIPE=1 side by side)
module tb_c17_array_bist;

    localparam int          NCH  = 4;
    localparam int          NPAT = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [5*NCH-1:0]  data_in;
    logic              bist_start;

    logic              out_valid0, out_valid1;
    logic [2*NCH-1:0]  data_out0, data_out1;
    logic              busy0, busy1, done0, done1;
    logic [15:0]       sig0, sig1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] golden;

    c17_array_bist #(.NUM_CH(NCH), .PIPE(0), .PATTERNS(NPAT), .SEED(SEED)) u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
        .bist_start(bist_start), .out_valid(out_valid0), .data_out(data_out0),
        .bist_busy(busy0), .bist_done(done0), .signature(sig0));

    c17_array_bist #(.NUM_CH(NCH), .PIPE(1), .PATTERNS(NPAT), .SEED(SEED)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
        .bist_start(bist_start), .out_valid(out_valid1), .data_out(data_out1),
        .bist_busy(busy1), .bist_done(done1), .signature(sig1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] c17(input logic [4:0] v);
        logic a1, a2, a3, a6, a7, g10, g11, g16, g19;
        {a7, a6, a3, a2, a1} = v;
        g10 = ~(a1 & a3);
        g11 = ~(a3 & a6);
        g16 = ~(a2 & g11);
        g19 = ~(g11 & a7);
        return {~(g16 & g19), ~(g10 & g16)};
    endfunction

    function automatic logic [2*NCH-1:0] model_out(input logic [5*NCH-1:0] v);
        logic [2*NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[2*c +: 2] = c17(v[5*c +: 5]);
        return r;
    endfunction

    function automatic logic [15:0] model_sig(input int n);
        logic [15:0] l, m, f;
        logic [5*NCH-1:0] v;
        logic [2*NCH-1:0] o;
        l = SEED;
        m = 16'h0;
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < 5*NCH; i++) v[i] = l[i % 16];
            o = model_out(v);
            f = 16'h0;
            for (int i = 0; i < 2*NCH; i++) f[i % 16] = f[i % 16] ^ o[i];
            m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0) ^ f;
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0);
        end
        return m;
    endfunction

    // Starts a BIST at the current negedge and observes both DUTs until done; no checks here.
    task automatic bist_run(input int pulse_at, output int b0, output int b1,
                            output logic [15:0] s0, output logic [15:0] s1,
                            output int done_early, output logic ov0, output logic ov1,
                            output logic [2*NCH-1:0] od0, output logic [2*NCH-1:0] od1,
                            output bit tmo);
        bist_start = 1'b1;
        in_valid   = 1'b0;
        b0 = 0; b1 = 0; done_early = 0; tmo = 1'b1;
        s0 = 16'h0; s1 = 16'h0; ov0 = 1'b0; ov1 = 1'b0; od0 = '0; od1 = '0;
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            bist_start = (pulse_at != 0) && (j == pulse_at);
            if (j == 1) begin
                ov0 = out_valid0; od0 = data_out0;
                if (done0 || done1) done_early++;
            end
            if (j == 2) begin
                ov1 = out_valid1; od1 = data_out1;
            end
            if (busy0) b0++;
            if (busy1) b1++;
            if (!busy0 && !busy1 && done0 && done1) begin
                tmo = 1'b0;
                s0 = sig0;
                s1 = sig1;
                break;
            end
        end
        bist_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; data_in = '0; bist_start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out_valid0, data_out0, busy0, done0, sig0} !== '0) begin
            n_fail++; $display("FAIL reset_u0 got %h want 0", {out_valid0, data_out0, busy0, done0, sig0});
        end
        n_checks++;
        if ({out_valid1, data_out1, busy1, done1, sig1} !== '0) begin
            n_fail++; $display("FAIL reset_u1 got %h want 0", {out_valid1, data_out1, busy1, done1, sig1});
        end
        reset = 1'b1;
    endtask

    task automatic test_functional_fixed();
        data_in  = {5'b00010, 5'b00101, 5'b11111, 5'b00000};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = '0;
        @(negedge clk);
        n_checks++;
        if (out_valid0 !== 1'b1 || data_out0 !== 8'b11_01_01_00) begin
            n_fail++; $display("FAIL fixed_u0 got v=%b d=%b want v=1 d=11010100", out_valid0, data_out0);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid1 !== 1'b1 || data_out1 !== 8'b11_01_01_00) begin
            n_fail++; $display("FAIL fixed_u1 got v=%b d=%b want v=1 d=11010100", out_valid1, data_out1);
        end
        n_checks++;
        if (out_valid0 !== 1'b0) begin
            n_fail++; $display("FAIL fixed_u0_bubble got v=%b want 0", out_valid0);
        end
    endtask

    task automatic test_streaming();
        localparam int N = 12;
        logic [5*NCH-1:0] vh[N];
        logic             kh[N];
        for (int m = 0; m < N + 3; m++) begin
            if (m < N) begin
                vh[m] = 20'($urandom);
                kh[m] = (m % 2 == 0) ? 1'b1 : 1'($urandom);
                data_in = vh[m]; in_valid = kh[m];
            end else begin
                data_in = '0; in_valid = 1'b0;
            end
            if (m >= 2 && m - 2 < N) begin
                n_checks++;
                if (out_valid0 !== kh[m-2] || (kh[m-2] && data_out0 !== model_out(vh[m-2]))) begin
                    n_fail++; $display("FAIL stream_u0[%0d] got v=%b d=%h want v=%b d=%h",
                                       m-2, out_valid0, data_out0, kh[m-2], model_out(vh[m-2]));
                end
            end
            if (m >= 3 && m - 3 < N) begin
                n_checks++;
                if (out_valid1 !== kh[m-3] || (kh[m-3] && data_out1 !== model_out(vh[m-3]))) begin
                    n_fail++; $display("FAIL stream_u1[%0d] got v=%b d=%h want v=%b d=%h",
                                       m-3, out_valid1, data_out1, kh[m-3], model_out(vh[m-3]));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bist();
        int b0, b1, de; logic [15:0] s0, s1; logic v0, v1; logic [2*NCH-1:0] d0, d1; bit tmo;
        for (int run = 0; run < 2; run++) begin
            bist_run(0, b0, b1, s0, s1, de, v0, v1, d0, d1, tmo);
            n_checks++;
            if (tmo) begin n_fail++; $display("FAIL bist_timeout run=%0d got busy/done stuck want done", run); end
            n_checks++;
            if (b0 != NPAT + 2 || b1 != NPAT + 3) begin
                n_fail++; $display("FAIL bist_busy_len run=%0d got %0d/%0d want %0d/%0d", run, b0, b1, NPAT+2, NPAT+3);
            end
            n_checks++;
            if (s0 !== golden || s1 !== golden) begin
                n_fail++; $display("FAIL bist_sig run=%0d got %h/%h want %h", run, s0, s1, golden);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done0 !== 1'b1 || done1 !== 1'b1 || sig0 !== golden || sig1 !== golden) begin
            n_fail++; $display("FAIL bist_hold got done=%b%b sig=%h/%h want 11 %h", done0, done1, sig0, sig1, golden);
        end
    endtask

    task automatic test_bist_guard();
        int b0, b1, de; logic [15:0] s0, s1; logic v0, v1; logic [2*NCH-1:0] d0, d1; bit tmo;
        bist_run(3, b0, b1, s0, s1, de, v0, v1, d0, d1, tmo);
        n_checks++;
        if (tmo || s0 !== golden || s1 !== golden || b0 != NPAT + 2 || b1 != NPAT + 3) begin
            n_fail++; $display("FAIL guard_midrun got sig=%h/%h busy=%0d/%0d want %h %0d/%0d",
                               s0, s1, b0, b1, golden, NPAT+2, NPAT+3);
        end
        bist_run(0, b0, b1, s0, s1, de, v0, v1, d0, d1, tmo);
        n_checks++;
        if (de != 0) begin n_fail++; $display("FAIL guard_restart_done got done high at start want low"); end
        n_checks++;
        if (tmo || s0 !== golden || s1 !== golden) begin
            n_fail++; $display("FAIL guard_restart_sig got %h/%h want %h", s0, s1, golden);
        end
    endtask

    task automatic test_reset_mid_bist();
        int b0, b1, de; logic [15:0] s0, s1; logic v0, v1; logic [2*NCH-1:0] d0, d1; bit tmo;
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({out_valid0, data_out0, busy0, done0, sig0, out_valid1, data_out1, busy1, done1, sig1} !== '0) begin
            n_fail++; $display("FAIL reset_mid got busy=%b%b sig=%h/%h want all 0", busy0, busy1, sig0, sig1);
        end
        @(negedge clk);
        reset = 1'b1;
        bist_run(0, b0, b1, s0, s1, de, v0, v1, d0, d1, tmo);
        n_checks++;
        if (tmo || s0 !== golden || s1 !== golden) begin
            n_fail++; $display("FAIL reset_mid_rerun got %h/%h want %h", s0, s1, golden);
        end
    endtask

    task automatic test_overlap();
        int b0, b1, de; logic [15:0] s0, s1; logic v0, v1; logic [2*NCH-1:0] d0, d1; bit tmo;
        logic [5*NCH-1:0] vec;
        vec = 20'($urandom);
        data_in = vec; in_valid = 1'b1;
        @(negedge clk);
        data_in = '0;
        bist_run(0, b0, b1, s0, s1, de, v0, v1, d0, d1, tmo);
        n_checks++;
        if (v0 !== 1'b1 || d0 !== model_out(vec)) begin
            n_fail++; $display("FAIL overlap_u0 got v=%b d=%h want v=1 d=%h", v0, d0, model_out(vec));
        end
        n_checks++;
        if (v1 !== 1'b1 || d1 !== model_out(vec)) begin
            n_fail++; $display("FAIL overlap_u1 got v=%b d=%h want v=1 d=%h", v1, d1, model_out(vec));
        end
        n_checks++;
        if (tmo || s0 !== golden || s1 !== golden) begin
            n_fail++; $display("FAIL overlap_sig got %h/%h want %h", s0, s1, golden);
        end
    endtask

    initial begin
        golden = model_sig(NPAT);
        test_reset();
        @(negedge clk);
        test_functional_fixed();
        test_streaming();
        test_bist();
        test_bist_guard();
        test_reset_mid_bist();
        @(negedge clk);
        test_overlap();
        @(negedge clk);
        test_streaming();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
